// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: OPMODE field positions, X/Z select codes and saturation limits for the MAC slice
package dsp_mac_pkg;
  localparam int OP_PRE_B    = 4;
  localparam int OP_CIN      = 5;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_POST_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3;
  localparam int SAT_W = 256;
  function automatic logic [SAT_W-1:0] sat_max(input logic sgn, input int w);
    logic [SAT_W-1:0] r;
    r = {SAT_W{1'b1}} >> (SAT_W - w);
    return sgn ? r >> 1 : r;
  endfunction
  function automatic logic [SAT_W-1:0] sat_min(input logic sgn, input int w);
    return sgn ? {SAT_W{1'b1}} << (w - 1) : '0;
  endfunction
endpackage

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: enabled pipeline register with a valid bit; payload is kept on bubbles
module dsp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  // advance on enable; only real beats overwrite the payload
  always_comb begin
    valid_d = en ? in_valid : valid_q;
    data_d  = (en && in_valid) ? in_data : data_q;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pipelined pre-add / multiply / post-add MAC slice with flow control and saturation
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int C_WIDTH  = 48,
  parameter int P_WIDTH  = 48,
  parameter int SIGNED   = 1,
  parameter int IN_REG   = 1,
  parameter int MREG     = 1,
  parameter int SATURATE = 0,
  parameter logic [P_WIDTH-1:0] PATTERN = '0,
  parameter logic [P_WIDTH-1:0] MASK    = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [B_WIDTH-1:0] D,
  input  logic [C_WIDTH-1:0] C,
  input  logic [P_WIDTH-1:0] PCIN,
  input  logic [7:0]         OPMODE,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [P_WIDTH-1:0] P,
  output logic [P_WIDTH-1:0] PCOUT,
  output logic [B_WIDTH-1:0] BCOUT,
  output logic               CARRYOUT,
  output logic               OVERFLOW,
  output logic               PATTERN_DET
);
  localparam int AB_W = A_WIDTH + B_WIDTH;
  localparam int RW   = P_WIDTH + 2;
  localparam int S1_W = 8 + P_WIDTH + C_WIDTH + 2 * B_WIDTH + A_WIDTH;
  localparam int S2_W = 6 + 2 * P_WIDTH + C_WIDTH + B_WIDTH + AB_W;
  localparam logic SGN = SIGNED != 0;
  localparam logic SAT = SATURATE != 0;
  localparam logic [P_WIDTH-1:0] P_MAX = P_WIDTH'(sat_max(SGN, P_WIDTH));
  localparam logic [P_WIDTH-1:0] P_MIN = P_WIDTH'(sat_min(SGN, P_WIDTH));

  logic en;
  logic out_valid_d, out_valid_q, cy_d, cy_q, ov_d, ov_q;
  logic [P_WIDTH-1:0] p_d, p_q;

  assign en = ~out_valid_q | OUT_READY;

  logic              v1;
  logic [S1_W-1:0]   s1_in, s1;
  logic [7:0]        op1;
  logic [P_WIDTH-1:0] pcin1;
  logic [C_WIDTH-1:0] c1;
  logic [B_WIDTH-1:0] d1, b1;
  logic [A_WIDTH-1:0] a1;

  assign s1_in = {OPMODE, PCIN, C, D, A, B};
  assign {op1, pcin1, c1, d1, a1, b1} = s1;

  generate
    if (IN_REG != 0) begin : g_s1
      dsp_pipe_stage #(.W(S1_W)) u_s1 (
        .clk(CLK), .rst(RST), .en(en), .in_valid(IN_VALID), .in_data(s1_in),
        .out_valid(v1), .out_data(s1)
      );
    end else begin : g_s1_byp
      assign v1 = IN_VALID;
      assign s1 = s1_in;
    end
  endgenerate

  logic [B_WIDTH-1:0] pre, bmul;
  logic [AB_W-1:0]    m_s, m_u, m;
  // pre-adder feeding the multiplier B port, then the full-width product
  always_comb begin
    pre  = op1[OP_PRE_SUB] ? d1 - b1 : d1 + b1;
    bmul = op1[OP_PRE_B] ? pre : b1;
    m_s  = AB_W'($signed(a1)) * AB_W'($signed(bmul));
    m_u  = AB_W'(a1) * AB_W'(bmul);
    m    = SGN ? m_s : m_u;
  end

  logic               v2;
  logic [S2_W-1:0]    s2_in, s2;
  logic               post_sub2, cin2;
  logic [1:0]         zsel2, xsel2;
  logic [P_WIDTH-1:0] pcin2, dab2;
  logic [C_WIDTH-1:0] c2;
  logic [B_WIDTH-1:0] bmul2;
  logic [AB_W-1:0]    m2;

  assign s2_in = {op1[OP_POST_SUB], op1[OP_CIN], op1[3:0], pcin1, c1, P_WIDTH'({d1, a1, b1}), bmul, m};
  assign {post_sub2, cin2, zsel2, xsel2, pcin2, c2, dab2, bmul2, m2} = s2;

  generate
    if (MREG != 0) begin : g_s2
      dsp_pipe_stage #(.W(S2_W)) u_s2 (
        .clk(CLK), .rst(RST), .en(en), .in_valid(v1), .in_data(s2_in),
        .out_valid(v2), .out_data(s2)
      );
    end else begin : g_s2_byp
      assign v2 = v1;
      assign s2 = s2_in;
    end
  endgenerate

  logic [P_WIDTH-1:0] x, z, m_ext, c_ext, res;
  logic [RW-1:0]      xe, ze, r;
  logic               ovf;
  // post-adder computed two bits wider than P so overflow and carry are exact
  always_comb begin
    m_ext = SGN ? P_WIDTH'($signed(m2)) : P_WIDTH'(m2);
    c_ext = SGN ? P_WIDTH'($signed(c2)) : P_WIDTH'(c2);
    x = xsel2 == X_M ? m_ext : xsel2 == X_P ? p_q : xsel2 == X_DAB ? dab2 : '0;
    z = zsel2 == Z_PCIN ? pcin2 : zsel2 == Z_P ? p_q : zsel2 == Z_C ? c_ext : '0;
    xe = SGN ? RW'($signed(x)) : RW'(x);
    ze = SGN ? RW'($signed(z)) : RW'(z);
    r = post_sub2 ? ze - xe - RW'(cin2) : ze + xe + RW'(cin2);
    ovf = SGN ? (r[RW-1:P_WIDTH-1] != 3'b000 && r[RW-1:P_WIDTH-1] != 3'b111) : r[RW-1:P_WIDTH] != 2'b00;
    res = (SAT && ovf) ? (r[RW-1] ? P_MIN : P_MAX) : r[P_WIDTH-1:0];
    p_d = (en && v2) ? res : p_q;
    cy_d = (en && v2) ? r[P_WIDTH] ^ ze[P_WIDTH] ^ xe[P_WIDTH] : cy_q;
    ov_d = (en && v2) ? ovf : ov_q;
    out_valid_d = en ? v2 : out_valid_q;
  end

  // result register and flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q         <= '0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY    = en;
  assign OUT_VALID   = out_valid_q;
  assign P           = p_q;
  assign PCOUT       = p_q;
  assign BCOUT       = bmul2;
  assign CARRYOUT    = cy_q;
  assign OVERFLOW    = ov_q;
  assign PATTERN_DET = ((p_q ^ PATTERN) & ~MASK) == '0;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed vectors against a wrapping and a saturating slice
module tb_dsp_mac_pipe;
  logic CLK = 1'b0, RST = 1'b1;
  logic [17:0] A = '0, B = '0, D = '0;
  logic [47:0] C = '0, PCIN = '0;
  logic [7:0]  OPMODE = '0;
  logic IN_VALID = 1'b0, OUT_READY = 1'b1;
  logic in_ready, out_valid, carry, ovf, pdet;
  logic [47:0] p, pcout;
  logic [17:0] bcout;
  logic s_in_ready, s_out_valid, s_carry, s_ovf, s_pdet;
  logic [47:0] s_p, s_pcout;
  logic [17:0] s_bcout;
  int n_chk = 0, n_pass = 0;
  int lat;

  always #5 CLK = ~CLK;

  dsp_mac_pipe u_dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .IN_VALID(IN_VALID), .IN_READY(in_ready), .OUT_VALID(out_valid), .OUT_READY(OUT_READY),
    .P(p), .PCOUT(pcout), .BCOUT(bcout), .CARRYOUT(carry), .OVERFLOW(ovf), .PATTERN_DET(pdet)
  );

  dsp_mac_pipe #(.SATURATE(1)) u_sat (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .IN_VALID(IN_VALID), .IN_READY(s_in_ready), .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY),
    .P(s_p), .PCOUT(s_pcout), .BCOUT(s_bcout), .CARRYOUT(s_carry), .OVERFLOW(s_ovf), .PATTERN_DET(s_pdet)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [17:0] a, b, d, input logic [47:0] c, input logic [7:0] op);
    A = a; B = b; D = d; C = c; OPMODE = op; IN_VALID = 1'b1;
  endtask

  task automatic reset_dut;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    RST = 1'b1;
    tick;
    tick;
    RST = 1'b0;
  endtask

  task automatic send(input logic [17:0] a, b, d, input logic [47:0] c, input logic [7:0] op, output int l);
    drive(a, b, d, c, op);
    #1;
    chk("accept", in_ready, 1);
    tick;
    IN_VALID = 1'b0;
    l = 1;
    while (!out_valid && l < 20) begin
      tick;
      l++;
    end
  endtask

  task automatic run_acc(input bit stall, input string nm);
    int bi = 0, k = 0, stalls = 0, first = -1, last = 0;
    logic acc;
    logic [47:0] exp_p [4];
    exp_p = '{48'd1, 48'd3, 48'd6, 48'd10};
    for (int t = 0; t < 40 && k < 4; t++) begin
      OUT_READY = !(stall && out_valid && stalls < 5);
      if (!OUT_READY) stalls++;
      if (bi < 4) drive(18'd1, 18'(bi + 1), 18'd0, 48'd0, 8'h09);
      else IN_VALID = 1'b0;
      #1;
      acc = IN_VALID & in_ready;
      if (!OUT_READY) begin
        chk({nm, "_in_ready_stalled"}, in_ready, 0);
        chk({nm, "_p_hold"}, p, 48'd1);
      end
      if (out_valid && OUT_READY) begin
        chk($sformatf("%s_p%0d", nm, k), p, exp_p[k]);
        if (first < 0) first = t;
        last = t;
        k++;
      end
      tick;
      if (acc) bi++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    chk({nm, "_results"}, k, 4);
    chk({nm, "_accepted"}, bi, 4);
    if (stall) chk({nm, "_stalls"}, stalls, 5);
    else chk({nm, "_span"}, last - first, 3);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_out_valid", {out_valid, s_out_valid}, 2'b00);
    chk("rst_p", p, 0);
    chk("rst_pcout", {pcout, s_pcout}, 0);
    chk("rst_bcout", {bcout, s_bcout}, 0);
    chk("rst_flags", {carry, ovf, s_carry, s_ovf}, 0);
    chk("rst_pdet", {pdet, s_pdet}, 2'b11);
    chk("rst_in_ready", {in_ready, s_in_ready}, 2'b11);
    RST = 1'b0;

    send(18'd3, 18'h3FFFB, 18'd0, 48'd0, 8'h01, lat);
    chk("t1_latency", lat, 3);
    chk("t1_p", p, 48'hFFFF_FFFF_FFF1);
    chk("t1_pcout", pcout, 48'hFFFF_FFFF_FFF1);
    chk("t1_sat_p", s_p, 48'hFFFF_FFFF_FFF1);
    chk("t1_carry", carry, 0);
    chk("t1_ovf", ovf, 0);

    send(18'd2, 18'd4, 18'd10, 48'd0, 8'h51, lat);
    chk("t2_latency", lat, 3);
    chk("t2_p", p, 48'd12);
    chk("t2_bcout", bcout, 18'd6);

    reset_dut;
    run_acc(1'b0, "t3");
    reset_dut;
    run_acc(1'b1, "t4");

    send(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 8'h0D, lat);
    chk("t5a_sat_p", s_p, 48'h7FFF_FFFF_FFFF);
    chk("t5a_sat_pcout", s_pcout, 48'h7FFF_FFFF_FFFF);
    chk("t5a_sat_ovf", s_ovf, 1);
    chk("t5a_wrap_p", p, 48'h8000_0000_0000);
    chk("t5a_wrap_ovf", ovf, 1);
    chk("t5a_carry", carry, 0);
    send(18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 8'h8D, lat);
    chk("t5b_sat_p", s_p, 48'h8000_0000_0000);
    chk("t5b_sat_ovf", s_ovf, 1);
    chk("t5b_wrap_p", p, 48'h7FFF_FFFF_FFFF);
    chk("t5b_wrap_ovf", ovf, 1);
    chk("t5b_carry", carry, 0);

    drive(18'd2, 18'd3, 18'd0, 48'd0, 8'h01);
    tick;
    drive(18'd4, 18'd5, 18'd0, 48'd0, 8'h01);
    tick;
    IN_VALID = 1'b0;
    tick;
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_p", p, 48'd6);
    chk("t6_pre_bcout", bcout, 18'd5);
    #3;
    RST = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_p", p, 0);
    chk("t6_rst_bcout", bcout, 0);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("t6_flushed%0d", i), out_valid, 0);
    end
    send(18'd7, 18'd9, 18'd0, 48'd0, 8'h00, lat);
    chk("t6_latency", lat, 3);
    chk("t6_p", p, 0);
    chk("t6_pdet", pdet, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised, signed/unsigned multiply-accumulate slice: pre-adder, multiplier, post-adder/accumulator. Supersedes the fixed 18x18/48 slice. Adds generic widths, per-beat OPMODE carried with the data, valid/ready flow control with backpressure, saturation with overflow flag, and masked pattern detect. Sits in filter/MAC datapaths; PCOUT cascades into the PCIN of the next slice.

Parameters:
A_WIDTH, 18, width of A.
B_WIDTH, 18, width of B, D, BCOUT and the pre-adder result.
C_WIDTH, 48, width of C (sign- or zero-extended to P_WIDTH); C_WIDTH <= P_WIDTH.
P_WIDTH, 48, width of P/PCIN/PCOUT; P_WIDTH >= A_WIDTH+B_WIDTH.
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
IN_REG, 1, 0/1: input register stage present.
MREG, 1, 0/1: multiplier register stage present.
SATURATE, 0, 1 = clamp on overflow.
PATTERN, 0, pattern value (P_WIDTH bits).
MASK, 0, pattern mask (1 = bit ignored).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset of all state
A  in  A_WIDTH  multiplier operand
B  in  B_WIDTH  multiplier / pre-adder operand
D  in  B_WIDTH  pre-adder operand
C  in  C_WIDTH  post-adder operand
PCIN  in  P_WIDTH  cascade input
OPMODE  in  8  per-beat mode
IN_VALID  in  1  input beat valid
IN_READY  out  1  slice accepts a beat
OUT_VALID  out  1  P/flags valid
OUT_READY  in  1  downstream accepts result
P  out  P_WIDTH  result
PCOUT  out  P_WIDTH  copy of P
BCOUT  out  B_WIDTH  registered multiplier B operand
CARRYOUT  out  1  post-adder carry/borrow bit
OVERFLOW  out  1  signed/unsigned range overflow of the result
PATTERN_DET  out  1  ((P ^ PATTERN) & ~MASK) == 0

Behaviour:
- Reset: RST asynchronous, active-high. Clock is CLK. While RST is high, all data registers, per-stage valid bits and per-stage OPMODE copies are 0. So OUT_VALID=0, P=PCOUT=0, BCOUT=0, CARRYOUT=0, OVERFLOW=0, PATTERN_DET=1 iff (PATTERN & ~MASK)==0. In-flight beats are discarded.
- Stages: S1 input (bypassed if IN_REG=0) -> S2 pre-add+multiply (M register bypassed if MREG=0) -> S3 post-add (P register, always present). Latency from accept to OUT_VALID = IN_REG+MREG+1 cycles (3 at defaults).
- Flow: en = ~OUT_VALID | OUT_READY. IN_READY = en (combinational). A beat is accepted when IN_VALID & IN_READY. All stages advance together when en=1 and hold when en=0. Each stage carries a valid bit and its own OPMODE copy. Bubbles propagate as valid=0.
- The P register, CARRYOUT, OVERFLOW and PATTERN_DET update only when en=1 and the S3-input valid=1. Bubbles never alter P.
- OPMODE: [1:0] X select: 0 / M extended / P / {D,A,B} zero-extended or truncated to P_WIDTH. [3:2] Z select: 0 / PCIN / P / C extended. [4] = use pre-adder result as multiplier B. [5] = carry-in. [6] = pre-subtract (D-B). [7] = post-subtract.
- Pre-adder: D±B wraps to B_WIDTH. BCOUT is the B operand entering the multiplier.
- M = A*B at A_WIDTH+B_WIDTH bits, signed if SIGNED. Extension to P_WIDTH follows SIGNED.
- Post-adder: R = Z + (X + cin) or Z - (X + cin), computed exactly in P_WIDTH+2 bits.
  - CARRYOUT = bit P_WIDTH of the unsigned P_WIDTH+1-bit sum/difference.
  - OVERFLOW = R outside the P_WIDTH range (signed or unsigned per SIGNED).
  - SATURATE=1: P clamps to max/min on overflow. SATURATE=0: P wraps.
- Z=P and X=P feed back the current P register (the last valid result), so back-to-back accumulation is exact.
- Simultaneous accept and output consume in the same cycle is legal (full throughput).

Decomposition:
- Package dsp_mac_pkg holds OPMODE bit-index localparams, the X/Z select encodings, and the saturation max/min functions.
- One sub-module: dsp_pipe_stage, a parametrised-width register with valid, enable and async reset. Instantiated per stage. IN_REG and MREG bypass it via generate.

Test Plan:
1. Defaults, A=3, B=-5, OPMODE=8'h01, one beat -> OUT_VALID 3 cycles after accept; P=48'hFFFF_FFFF_FFF1; CARRYOUT=0; OVERFLOW=0.
2. D=10, B=4, A=2, OPMODE=8'h51 -> pre-add 6, P=12, BCOUT=6.
3. Accumulate after reset, OPMODE=8'h09, A=1, B=1,2,3,4 back-to-back, OUT_READY=1 -> P sequence 1,3,6,10 on consecutive cycles.
4. Repeat test 3 with OUT_READY=0 for 5 cycles after the first OUT_VALID -> IN_READY=0 while stalled; P holds 1; after release, sequence 3,6,10 with no loss or duplication.
5. SATURATE=1: C=48'h7FFF_FFFF_FFFF, A=B=1, OPMODE=8'h0D -> P=48'h7FFF_FFFF_FFFF, OVERFLOW=1. Then C=48'h8000_0000_0000, OPMODE=8'h8D -> P=48'h8000_0000_0000, OVERFLOW=1.
6. Two beats in flight, RST pulsed mid-cycle -> OUT_VALID, P and BCOUT go 0 immediately without a clock edge. After release, OPMODE=8'h00 beat -> P=0, PATTERN_DET=1 (PATTERN=0, MASK=0).
